// File: rtl/fwft_unpack_pkg.sv
// Shared helpers for the FWFT FIFO width down-converter.
// Optional feature macro used by the top level: FWFT_UNPACK_LAST_EN.
package fwft_unpack_pkg;

   // Holding-register state, exposed as an enum so it reads clearly in waves
   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } unpack_state_t;

   // Number of narrow lanes in one wide word
   function automatic int ratio(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Map the beat counter onto a physical lane; swap emits the top lane first
   function automatic int lane_idx(input int cnt, input int ratio_n, input bit swap);
      return swap ? (ratio_n - 1 - cnt) : cnt;
   endfunction

endpackage

// File: rtl/fwft_unpack_lane_sel.sv
// Combinational lane multiplexer: picks one OUT_WIDTH slice of the held word.
module fwft_unpack_lane_sel
   import fwft_unpack_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int IDX_W     = 2
) (
   input  logic [IN_WIDTH-1:0]  hold_data,
   input  logic [IDX_W-1:0]     idx,
   output logic [OUT_WIDTH-1:0] out_data
);

   localparam int RATIO = ratio(IN_WIDTH, OUT_WIDTH);

   logic [OUT_WIDTH-1:0] lanes [RATIO];

   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         assign lanes[gi] = hold_data[gi*OUT_WIDTH +: OUT_WIDTH];
      end
   endgenerate

   // Explicit compare chain so an out-of-range index yields zero, never X
   always_comb begin
      out_data = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (idx == IDX_W'(i)) out_data = lanes[i];
      end
   end

endmodule

// File: rtl/fwft_fifo_unpacker.sv
// Read-side width down-converter for a FWFT FIFO: pops one wide word and
// streams it out as IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready port.
// Optional macro FWFT_UNPACK_LAST_EN adds an out_last end-of-word marker.
module fwft_fifo_unpacker
   import fwft_unpack_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit WORD_SWAP = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_vld,
   output logic                 in_rden,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_vld,
   input  logic                 out_rdy,
`ifdef FWFT_UNPACK_LAST_EN
   output logic                 out_last,
`endif
   input  logic                 flush
);

   localparam int RATIO = ratio(IN_WIDTH, OUT_WIDTH);
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   generate
      if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
         $error("fwft_fifo_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
      end
   endgenerate

   unpack_state_t        state_reg, state_next;
   logic [IN_WIDTH-1:0]  hold_reg, hold_next;
   logic [CNT_W-1:0]     lane_cnt_reg, lane_cnt_next;
   logic [CNT_W-1:0]     lane_sel;
   logic                 hold_vld;
   logic                 last_lane;
   logic                 accept;

   assign hold_vld  = (state_reg == LOADED);
   assign last_lane = (lane_cnt_reg == CNT_W'(RATIO - 1));
   assign accept    = hold_vld && out_rdy;

   // Pop only when the holding register is free or is being drained this cycle
   assign in_rden = !rst && !flush && in_vld && (!hold_vld || (last_lane && out_rdy));

   // Register update; reset clears everything so out_data also reads zero
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= EMPTY;
         hold_reg     <= '0;
         lane_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         hold_reg     <= hold_next;
         lane_cnt_reg <= lane_cnt_next;
      end
   end

   // Next-state: flush beats load, load beats a plain lane advance
   always_comb begin
      state_next    = state_reg;
      hold_next     = hold_reg;
      lane_cnt_next = lane_cnt_reg;
      if (flush) begin
         state_next    = EMPTY;
         lane_cnt_next = '0;
      end else if (in_rden) begin
         state_next    = LOADED;
         hold_next     = in_data;
         lane_cnt_next = '0;
      end else if (accept) begin
         if (last_lane) begin
            state_next    = EMPTY;
            lane_cnt_next = '0;
         end else begin
            lane_cnt_next = lane_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign lane_sel = CNT_W'(lane_idx(int'(lane_cnt_reg), RATIO, WORD_SWAP));

   fwft_unpack_lane_sel #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .IDX_W     (CNT_W)
   ) u_lane_sel (
      .hold_data (hold_reg),
      .idx       (lane_sel),
      .out_data  (out_data)
   );

   assign out_vld = hold_vld;

`ifdef FWFT_UNPACK_LAST_EN
   assign out_last = hold_vld && last_lane;
`endif

endmodule
